led_pattern_checker: RTL and testbench

Decoding end of the KTNE LED-panel interface. Samples the 25-bit LED bus driven by the panel sequencer and decodes it back into a stage index. Tracks whether the panel walks the legal stage sequence 0→1→2→3→4, and raises solved, strike and exploded flags for the bomb top level. Sits between the LED panel FSM outputs and the game-status logic.

---
 rtl/ktne_pkg.sv | 34 +++
 rtl/led_pattern_decode.sv | 25 ++
 rtl/led_pattern_checker.sv | 145 ++++++++++++++
 tb/tb_led_pattern_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ktne_pkg.sv
// Shared KTNE LED-panel constants and types.
// Used by both the panel sequencer (encoder) and led_pattern_checker (decoder),
// so the stage patterns cannot diverge between the two ends of the bus.
// Bus layout: bit 24 = la ... bit 12 = lm (left bank), bit 11 = ra ... bit 0 = rl.
package ktne_pkg;

    localparam int unsigned LED_W = 25;

    // Stage patterns driven onto the LED bus.
    localparam logic [LED_W-1:0] PAT_S0 = 25'h1FF_FFFF;  // all lamps on
    localparam logic [LED_W-1:0] PAT_S1 = 25'h1FF_F000;  // left bank on
    localparam logic [LED_W-1:0] PAT_S2 = 25'h000_0FFF;  // right bank on
    localparam logic [LED_W-1:0] PAT_S3 = 25'h0AA_AAAA;  // alternating lamps
    localparam logic [LED_W-1:0] PAT_S4 = 25'h000_0000;  // all lamps off

    // Decoded stage index; INVALID sits well clear of the legal 0..4 range.
    typedef enum logic [2:0] {
        S0      = 3'd0,
        S1      = 3'd1,
        S2      = 3'd2,
        S3      = 3'd3,
        S4      = 3'd4,
        INVALID = 3'd7
    } stage_t;

    // Progress tracker states.
    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2,
        DEAD  = 2'd3
    } fsm_t;

endpackage

// File: rtl/led_pattern_decode.sv
// Combinational decode of the registered LED bus into a stage index.
// Ports:
//   leds_q   in  25  registered LED bus
//   stage_c  out  3  S0..S4 on an exact pattern match, INVALID otherwise
module led_pattern_decode
    import ktne_pkg::*;
(
    input  logic [24:0] leds_q,
    output stage_t      stage_c
);

    // Exact-match lookup against the shared pattern table.
    always_comb begin
        stage_c = INVALID;
        case (leds_q)
            PAT_S0:  stage_c = S0;
            PAT_S1:  stage_c = S1;
            PAT_S2:  stage_c = S2;
            PAT_S3:  stage_c = S3;
            PAT_S4:  stage_c = S4;
            default: stage_c = INVALID;
        endcase
    end

endmodule

// File: rtl/led_pattern_checker.sv
// Decoding end of the KTNE LED-panel interface. Filters the LED bus for
// stability, decodes it into a stage and checks the walk 0->1->2->3->4,
// reporting solved / strike / exploded to the game-status logic.
// Ports:
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous active-low reset
//   leds          in  25  panel bus
//   stage         out  3  last accepted stage 0..4
//   stage_valid   out  1  a legal S0 has been accepted since reset
//   strike        out  1  one-cycle pulse per strike
//   strike_count  out  2  saturating strike counter
//   solved        out  1  sticky, stage 4 reached legally
//   exploded      out  1  sticky, third strike taken
module led_pattern_checker
    import ktne_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] leds,
    output logic [2:0]  stage,
    output logic        stage_valid,
    output logic        strike,
    output logic [1:0]  strike_count,
    output logic        solved,
    output logic        exploded
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    logic [24:0]   leds_q;
    logic [3:0]    stab_cnt;
    logic          acc_done;
    logic [TW-1:0] tmo_cnt;
    fsm_t          state;
    stage_t        dec_c;

    logic          accept_c;
    logic          timeout_c;
    logic          do_strike_c;
    logic          set_valid_c;
    logic [2:0]    stage_nx_c;
    fsm_t          state_nx_c;
    logic [1:0]    cnt_nx_c;

    led_pattern_decode u_decode (
        .leds_q  (leds_q),
        .stage_c (dec_c)
    );

    // Accept once per stable run; acc_done blocks re-accepting a held value.
    assign accept_c  = (stab_cnt == 4'(STABLE_CYCLES)) && !acc_done;
    // Stage 4 is never seen in TRACK, so stage != 0 covers stages 1..3.
    assign timeout_c = (state == TRACK) && (stage != 3'd0) &&
                       (tmo_cnt == TW'(TIMEOUT - 1));

    // Event resolution; an accept always takes precedence over a timeout.
    always_comb begin
        do_strike_c = 1'b0;
        set_valid_c = 1'b0;
        stage_nx_c  = stage;
        state_nx_c  = state;
        cnt_nx_c    = strike_count;
        case (state)
            WAIT0: begin
                if (accept_c) begin
                    if (dec_c == S0) begin
                        state_nx_c  = TRACK;
                        stage_nx_c  = 3'd0;
                        set_valid_c = 1'b1;
                    end else begin
                        do_strike_c = 1'b1;
                    end
                end
            end
            TRACK: begin
                if (accept_c) begin
                    if (dec_c != INVALID && 3'(dec_c) == stage + 3'd1) begin
                        stage_nx_c = stage + 3'd1;
                        if (stage_nx_c == 3'd4) state_nx_c = DONE;
                    end else if (dec_c == S0) begin
                        stage_nx_c = 3'd0;
                    end else if (3'(dec_c) != stage) begin
                        // Re-accepting the current stage (after a glitch) is harmless.
                        do_strike_c = 1'b1;
                        stage_nx_c  = 3'd0;
                        state_nx_c  = WAIT0;
                    end
                end else if (timeout_c) begin
                    do_strike_c = 1'b1;
                    stage_nx_c  = 3'd0;
                    state_nx_c  = WAIT0;
                end
            end
            default: ;  // DONE and DEAD are terminal until reset
        endcase
        if (do_strike_c) begin
            if (strike_count != 2'd3) cnt_nx_c = strike_count + 2'd1;
            if (cnt_nx_c == 2'd3) state_nx_c = DEAD;
        end
    end

    // Input capture, stability filter, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            leds_q       <= '0;
            stab_cnt     <= '0;
            acc_done     <= 1'b0;
            tmo_cnt      <= '0;
            state        <= WAIT0;
            stage        <= '0;
            stage_valid  <= 1'b0;
            strike       <= 1'b0;
            strike_count <= '0;
            solved       <= 1'b0;
            exploded     <= 1'b0;
        end else begin
            leds_q <= leds;
            if (leds != leds_q) begin
                stab_cnt <= 4'd1;
                acc_done <= 1'b0;
            end else begin
                if (stab_cnt != 4'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 4'd1;
                if (accept_c) acc_done <= 1'b1;
            end

            if (stage_nx_c != stage || stage_nx_c == 3'd0 || state_nx_c != TRACK) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TW'(TIMEOUT - 1)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            state        <= state_nx_c;
            stage        <= stage_nx_c;
            strike       <= do_strike_c;
            strike_count <= cnt_nx_c;
            if (set_valid_c)         stage_valid <= 1'b1;
            if (state_nx_c == DONE)  solved      <= 1'b1;
            if (state_nx_c == DEAD)  exploded    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_led_pattern_checker.sv
module tb_led_pattern_checker;
    import ktne_pkg::*;

    localparam int STABLE = 4;
    localparam int TMO    = 20;

    logic        clk;
    logic        reset;
    logic [24:0] leds;
    logic [2:0]  stage;
    logic        stage_valid;
    logic        strike;
    logic [1:0]  strike_count;
    logic        solved;
    logic        exploded;

    led_pattern_checker #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT       (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .leds         (leds),
        .stage        (stage),
        .stage_valid  (stage_valid),
        .strike       (strike),
        .strike_count (strike_count),
        .solved       (solved),
        .exploded     (exploded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_strikes = 0;
    int t_stage1  = -1;
    int t_strike  = -1;
    logic [2:0] prev_stage = 3'd0;

    logic [24:0] pats [5];

    // Behavioural model: run length of the sampled bus + game rules.
    int          m_stage, m_cnt, m_run, m_since;
    bit          m_valid, m_strike, m_solved, m_exploded, m_tracking;
    logic [24:0] m_last;

    function automatic int pat_idx(input logic [24:0] v);
        for (int i = 0; i < 5; i++) if (v == pats[i]) return i;
        return -1;
    endfunction

    task automatic hit();
        m_strike = 1'b1;
        m_cnt++;
        if (m_cnt == 3) m_exploded = 1'b1;
        m_stage = 0;
        m_tracking = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic [24:0] v);
        int old;
        int idx;
        if (!r) begin
            m_stage = 0; m_cnt = 0; m_run = 0; m_since = 0;
            m_valid = 0; m_strike = 0; m_solved = 0; m_exploded = 0;
            m_tracking = 0; m_last = '0;
            return;
        end
        m_strike = 1'b0;
        old = m_stage;
        if (!(m_solved || m_exploded)) begin
            if (m_run == STABLE) begin
                idx = pat_idx(m_last);
                if (!m_tracking) begin
                    if (idx == 0) begin
                        m_tracking = 1'b1; m_valid = 1'b1; m_stage = 0;
                    end else hit();
                end else if (idx >= 0 && idx == m_stage + 1) begin
                    m_stage = idx;
                    if (m_stage == 4) m_solved = 1'b1;
                end else if (idx == 0) begin
                    m_stage = 0;
                end else if (idx != m_stage) begin
                    hit();
                end
            end else if (m_tracking && m_stage >= 1 && m_since + 1 >= TMO) begin
                hit();
            end
        end
        if (m_stage != old || m_stage == 0 || !m_tracking) m_since = 0;
        else m_since++;
        if (m_run == 0 || v != m_last) m_run = 1;
        else if (m_run < 1000) m_run++;
        m_last = v;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("stage",        int'(stage),        m_stage);
        chk("stage_valid",  int'(stage_valid),  int'(m_valid));
        chk("strike",       int'(strike),       int'(m_strike));
        chk("strike_count", int'(strike_count), m_cnt);
        chk("solved",       int'(solved),       int'(m_solved));
        chk("exploded",     int'(exploded),     int'(m_exploded));
    endtask

    task automatic step(input logic r, input logic [24:0] v);
        reset = r;
        leds  = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
        compare_all();
        if (strike === 1'b1) begin
            n_strikes++;
            t_strike = cyc;
        end
        if (stage == 3'd1 && prev_stage != 3'd1) t_stage1 = cyc;
        prev_stage = stage;
        cyc++;
    endtask

    task automatic hold(input logic r, input logic [24:0] v, input int n);
        for (int i = 0; i < n; i++) step(r, v);
    endtask

    task automatic walk_to(input int s);
        for (int i = 0; i <= s; i++) hold(1'b1, pats[i], 6);
    endtask

    initial begin
        logic [24:0] rv;
        int sel;
        pats[0] = PAT_S0; pats[1] = PAT_S1; pats[2] = PAT_S2;
        pats[3] = PAT_S3; pats[4] = PAT_S4;
        reset = 1'b0;
        leds  = PAT_S0;

        // Reset, then S0 accepted on the 5th edge after release.
        hold(1'b0, PAT_S0, 2);
        hold(1'b1, PAT_S0, 4);
        chk("lit_valid_before_window", int'(stage_valid), 0);
        step(1'b1, PAT_S0);
        chk("lit_valid_after_window", int'(stage_valid), 1);
        chk("lit_stage0", int'(stage), 0);
        chk("lit_model_valid", int'(m_valid), 1);

        // Legal walk to solved, then random bus is ignored.
        n_strikes = 0;
        hold(1'b1, PAT_S0, 1);
        for (int i = 1; i < 5; i++) begin
            hold(1'b1, pats[i], 6);
            chk("lit_walk_stage", int'(stage), i);
        end
        rv = 25'($urandom);
        hold(1'b1, rv, 10);
        chk("lit_solved_sticky", int'(solved), 1);
        chk("lit_walk_no_strike", n_strikes, 0);

        // Three skip strikes explode the bomb.
        hold(1'b0, PAT_S0, 2);
        n_strikes = 0;
        for (int k = 1; k <= 3; k++) begin
            walk_to(1);
            hold(1'b1, PAT_S3, 6);
            chk("lit_skip_count", int'(strike_count), k);
            chk("lit_skip_stage", int'(stage), 0);
        end
        chk("lit_exploded", int'(exploded), 1);
        walk_to(2);
        chk("lit_dead_ignores", int'(stage), 0);
        chk("lit_skip_pulses", n_strikes, 3);

        // Short glitch from stage 2 has no effect.
        hold(1'b0, PAT_S0, 2);
        walk_to(2);
        hold(1'b1, PAT_S3, 2);
        hold(1'b1, PAT_S2, 6);
        chk("lit_glitch_stage", int'(stage), 2);
        chk("lit_glitch_count", int'(strike_count), 0);

        // Timeout in stage 1: one strike exactly TMO edges later.
        hold(1'b0, PAT_S0, 2);
        n_strikes = 0;
        t_stage1 = -1;
        t_strike = -1;
        walk_to(1);
        hold(1'b1, PAT_S1, 40);
        chk("lit_tmo_pulses", n_strikes, 1);
        chk("lit_tmo_delay", t_strike - t_stage1, TMO);
        chk("lit_tmo_stage", int'(stage), 0);

        // Mid-sequence reset, then stale S3 strikes in WAIT0.
        hold(1'b0, PAT_S0, 2);
        walk_to(3);
        chk("lit_pre_reset_stage", int'(stage), 3);
        step(1'b0, PAT_S3);
        chk("lit_reset_stage", int'(stage), 0);
        chk("lit_reset_valid", int'(stage_valid), 0);
        hold(1'b1, PAT_S3, 6);
        chk("lit_stale_strike", int'(strike_count), 1);
        chk("lit_stale_valid", int'(stage_valid), 0);
        hold(1'b1, PAT_S0, 6);
        chk("lit_restart_valid", int'(stage_valid), 1);

        // Randomized segments against the model.
        hold(1'b0, PAT_S0, 2);
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                hold(1'b0, PAT_S0, $urandom_range(1, 2));
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 5)      rv = pats[(m_stage + 1) % 5];
                else if (sel < 8) rv = pats[$urandom_range(0, 4)];
                else              rv = 25'($urandom);
                if ($urandom_range(0, 9) == 0) hold(1'b1, rv, $urandom_range(18, 30));
                else                           hold(1'b1, rv, $urandom_range(1, 8));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
